fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and sequencing stage directly upstream of the 8-bit ALU. It holds the program counter, fetches 9-bit instructions from the combinational instruction ROM, and presents the decoded opcode/funcA/funcB fields to the ALU. It consumes the ALU's `overflow` flag to resolve BOF/BNO branches, stops on HALT, and counts retired instructions.

## Interface
- `PC_WIDTH`, 10, program counter width; addresses wrap modulo 2^PC_WIDTH.
- `CNT_WIDTH`, 16, retired-instruction counter width.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins execution at `start_addr`.
- `start_addr`  in  PC_WIDTH  entry address captured on `start`.
- `stall`  in  1  holds the EXEC state while high.
- `instr_in`  in  9  ROM data at address `pc`, combinational.
- `overflow`  in  1  ALU overflow flag.
- `pc`  out  PC_WIDTH  current fetch address, also the ROM address.
- `ir`  out  9  instruction register.
- `opcode`  out  3  `ir[8:6]`.
- `funcA`  out  3  `ir[5:3]`.
- `funcB`  out  1  `ir[5]`.
- `instr_valid`  out  1  high in EXEC; `ir` fields are valid for the ALU.
- `busy`  out  1  high in FETCH or EXEC.
- `halted`  out  1  high in HALTED.
- `instr_count`  out  CNT_WIDTH  instructions retired since the last `start`; saturates at all-ones.

## Operation
- States: IDLE, FETCH, EXEC, HALTED. Reset state is IDLE.
- IDLE:
  - `start`=1 → pc←`start_addr`, instr_count←0, go to FETCH.
  - `start`=0 → hold.
- FETCH: ir←`instr_in`, go to EXEC.
- EXEC: `instr_valid`=1. The instruction retires at the edge that leaves EXEC with `stall`=0, and instr_count increments (saturating).
  - HALT (opcode 110, funcA 111): pc holds, go to HALTED. HALT counts as retired.
  - Branch (opcode 111): offset = sign-extend(`ir[4:0]`), range -16..+15.
    - Taken when funcB=1 (BOF) and `overflow`=1, or funcB=0 (BNO) and `overflow`=0.
    - Taken → pc←pc+offset, modulo 2^PC_WIDTH.
    - Not taken → pc←pc+1.
    - Go to FETCH.
  - All other instructions: pc←pc+1 (wraps from 2^PC_WIDTH-1 to 0), go to FETCH.
  - `stall`=1 → hold state, pc, ir and instr_count; `instr_valid` stays 1.
- HALTED:
  - `start`=1 → restart exactly as from IDLE.
  - Otherwise hold pc, ir and instr_count.
- `start` is ignored in FETCH and EXEC.
- Offset 0 taken is a self-loop at the same pc. It is legal and is not a halt.

## Timing
- Reset values while `reset_n`=0, asserted asynchronously: pc=0, ir=0, state IDLE, `instr_valid`=0, `busy`=0, `halted`=0, `instr_count`=0.
- Reset deassertion is synchronised by the user. Reset in any state aborts immediately with no retirement.
- Unstalled throughput is 2 cycles per instruction: FETCH then EXEC.
- `start` sampled at edge N → FETCH during cycle N+1, with `pc`=`start_addr` → EXEC during N+2.
- `overflow` is sampled at the rising edge that ends EXEC. The ALU updates its flag on the falling edge inside EXEC, so a branch sees the flag as left by the previous ALU instruction.
- The opcode/funcA/funcB outputs are purely combinational from `ir`. `instr_valid`, `busy` and `halted` decode from state only.

## Test plan
- Reset mid-EXEC with pc=0x05: assert `reset_n`=0 → pc=0, ir=0, all flags 0, `instr_count`=0, asynchronously before the next edge.
- Straight-line program at `start_addr`=0x3FE with 3 ADDs, then HALT at 0x001:
  - pc sequence 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
  - `halted`=1 after 8 cycles; `instr_count`=4.
- BOF offset -3 at pc 0x010:
  - `overflow`=1 → next pc 0x00D.
  - `overflow`=0 → next pc 0x011.
  - BNO mirrors both cases.
- `stall` held 3 cycles in EXEC:
  - `instr_valid` stays 1; pc and `instr_count` unchanged.
  - Retirement occurs on the first edge with `stall`=0.
- `start` pulsed during FETCH/EXEC → ignored.
- `start` from HALTED with `start_addr`=0x020 → pc=0x020, `instr_count` cleared, `halted`=0 next cycle.
- `CNT_WIDTH`=4, loop branch to self 20 times → `instr_count` saturates at 0xF.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage feeding the 8-bit ALU: PC, IR, field decode,
// BOF/BNO branch resolution, HALT handling and a saturating retired-instruction counter.
module fetch_unit #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_addr,
  input  logic                 stall,
  input  logic [8:0]           instr_in,
  input  logic                 overflow,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [8:0]           ir,
  output logic [2:0]           opcode,
  output logic [2:0]           funcA,
  output logic                 funcB,
  output logic                 instr_valid,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] FA_HALT = 3'b111;
  localparam logic [2:0] OP_BR   = 3'b111;

  state_t              state, next_state;
  logic                is_halt, is_branch, taken, retire;
  logic [PC_WIDTH-1:0] offset, pc_next;

  assign opcode = ir[8:6];
  assign funcA  = ir[5:3];
  assign funcB  = ir[5];

  assign is_halt   = (opcode == OP_HALT) && (funcA == FA_HALT);
  assign is_branch = (opcode == OP_BR);
  // BOF takes on overflow set, BNO on overflow clear
  assign taken     = funcB ? overflow : ~overflow;
  assign offset    = PC_WIDTH'($signed(ir[4:0]));
  assign retire    = (state == EXEC) && !stall;

  always_comb begin
    pc_next = pc + PC_WIDTH'(1);
    if (is_halt)                pc_next = pc;
    else if (is_branch && taken) pc_next = pc + offset;
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, HALTED: if (start) next_state = FETCH;
      FETCH:        next_state = EXEC;
      EXEC:         if (!stall) next_state = is_halt ? HALTED : FETCH;
      default:      next_state = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    unique case (state)
      FETCH:   busy = 1'b1;
      EXEC:    begin busy = 1'b1; instr_valid = 1'b1; end
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      if ((state == IDLE || state == HALTED) && start) begin
        pc          <= start_addr;
        instr_count <= '0;
      end
      if (state == FETCH) ir <= instr_in;
      if (retire) begin
        pc <= pc_next;
        if (instr_count != '1) instr_count <= instr_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, straight-line/wrap, branches, stall,
// start filtering, restart, async reset and counter saturation (second 4-bit instance).
module tb_fetch_unit;

  localparam logic [8:0] ADD  = 9'h00A;  // op 000
  localparam logic [8:0] HALT = 9'h1B8;  // op 110 funcA 111
  localparam logic [8:0] BOFM3 = 9'h1FD; // op 111, b5=1, off -3
  localparam logic [8:0] BNOM3 = 9'h1DD; // op 111, b5=0, off -3
  localparam logic [8:0] LOOP = 9'h1C0;  // BNO offset 0

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, stall, overflow;
  logic [9:0] start_addr;
  logic [8:0] instr_in;
  logic [9:0] pc;
  logic [8:0] ir;
  logic [2:0] opcode, funcA;
  logic       funcB, instr_valid, busy, halted;
  logic [15:0] instr_count;

  logic       start2;
  logic [9:0] pc2;
  logic [8:0] instr_in2, ir2;
  logic [2:0] opcode2, funcA2;
  logic       funcB2, instr_valid2, busy2, halted2;
  logic [3:0] instr_count2;

  logic [8:0] rom [1024];

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  assign instr_in  = rom[pc];
  assign instr_in2 = LOOP;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .instr_in(instr_in), .overflow(overflow), .pc(pc), .ir(ir),
    .opcode(opcode), .funcA(funcA), .funcB(funcB), .instr_valid(instr_valid),
    .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  fetch_unit #(.PC_WIDTH(10), .CNT_WIDTH(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start2), .start_addr(10'h000),
    .stall(1'b0), .instr_in(instr_in2), .overflow(1'b0), .pc(pc2), .ir(ir2),
    .opcode(opcode2), .funcA(funcA2), .funcB(funcB2), .instr_valid(instr_valid2),
    .busy(busy2), .halted(halted2), .instr_count(instr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // pulse start for one edge; afterwards the DUT is in FETCH at addr
  task automatic kick(input logic [9:0] addr);
    start = 1'b1;
    start_addr = addr;
    tick();
    start = 1'b0;
  endtask

  task automatic branch_case(input string tag, input logic [9:0] addr,
                             input logic ovf, input logic [9:0] exp_pc);
    overflow = ovf;
    kick(addr);
    tick();
    chk({tag, "_exec_valid"}, 32'(instr_valid), 32'd1);
    tick();
    chk({tag, "_next_pc"}, 32'(pc), 32'(exp_pc));
    tick();
    tick();
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = ADD;
    rom[10'h3FE] = ADD;  rom[10'h3FF] = ADD;  rom[10'h000] = ADD;  rom[10'h001] = HALT;
    rom[10'h020] = HALT;
    rom[10'h010] = BOFM3; rom[10'h00D] = HALT; rom[10'h011] = HALT;
    rom[10'h030] = BNOM3; rom[10'h02D] = HALT; rom[10'h031] = HALT;
    rom[10'h040] = ADD;   rom[10'h041] = HALT;

    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; stall = 1'b0;
    overflow = 1'b0; start_addr = '0;
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", 32'({instr_valid, busy, halted}), 32'h0);
    chk("rst_cnt", 32'(instr_count), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("idle_hold", 32'({busy, halted}), 32'h0);

    // straight-line with wrap, start filtered in FETCH/EXEC
    kick(10'h3FE);
    chk("sl_fetch_pc", 32'(pc), 32'h3FE);
    chk("sl_fetch_busy", 32'({busy, instr_valid}), 32'h2);
    tick();
    chk("sl_exec_ir", 32'(ir), 32'(ADD));
    chk("sl_fields", 32'({opcode, funcA, funcB}), 32'({3'b000, 3'b001, 1'b0}));
    tick();
    chk("sl_pc1", 32'(pc), 32'h3FF);
    start = 1'b1; start_addr = 10'h100;
    tick();
    chk("ign_start_exec_pc", 32'(pc), 32'h3FF);
    chk("ign_start_valid", 32'(instr_valid), 32'd1);
    tick();
    start = 1'b0;
    chk("sl_pc_wrap", 32'(pc), 32'h000);
    tick();
    tick();
    chk("sl_pc3", 32'(pc), 32'h001);
    tick();
    chk("sl_halt_ir", 32'({opcode, funcA}), 32'h37);
    chk("sl_cnt3", 32'(instr_count), 32'd3);
    tick();
    chk("sl_halted", 32'(halted), 32'd1);
    chk("sl_cnt4", 32'(instr_count), 32'd4);
    chk("sl_halt_pc", 32'(pc), 32'h001);
    tick();
    chk("halt_hold", 32'({halted, 6'(pc)}), 32'({1'b1, 6'h01}));

    // restart from HALTED
    kick(10'h020);
    chk("rs_pc", 32'(pc), 32'h020);
    chk("rs_cnt", 32'(instr_count), 32'd0);
    chk("rs_halted", 32'({halted, busy}), 32'h1);
    tick();
    tick();
    chk("rs_cnt1", 32'(instr_count), 32'd1);

    // branches
    branch_case("bof_taken", 10'h010, 1'b1, 10'h00D);
    branch_case("bof_not",   10'h010, 1'b0, 10'h011);
    branch_case("bno_taken", 10'h030, 1'b0, 10'h02D);
    branch_case("bno_not",   10'h030, 1'b1, 10'h031);

    // stall in EXEC
    kick(10'h040);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", 32'(pc), 32'h040);
      chk("stall_cnt", 32'(instr_count), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc", 32'(pc), 32'h041);
    chk("unstall_cnt", 32'(instr_count), 32'd1);
    tick();
    tick();
    chk("unstall_halted", 32'(halted), 32'd1);

    // async reset mid-EXEC at pc 0x005
    kick(10'h005);
    tick();
    chk("pre_rst_pc", 32'(pc), 32'h005);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_ir", 32'(ir), 32'h0);
    chk("arst_flags", 32'({instr_valid, busy, halted}), 32'h0);
    chk("arst_cnt", 32'(instr_count), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // saturation on the 4-bit counter instance: self-loop
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("sat_cnt15", 32'(instr_count2), 32'hF);
    for (int k = 0; k < 10; k++) tick();
    chk("sat_cnt20", 32'(instr_count2), 32'hF);
    chk("sat_pc", 32'(pc2), 32'h000);
    chk("sat_not_halt", 32'({halted2, busy2}), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
